pcm_frame_packer: RTL and testbench
===================================

// Module: pcm_frame_packer
// PURPOSE
//   Serialises multi-channel PCM sample frames into a byte stream for the SPI TX FIFO.
//   Inserts a configurable sync word every SYNC_INTERVAL frames so the host can realign.
//   Drops and counts frames that arrive while a previous frame is still draining.
//   Sits between the I2S receive/decimation path (already synchronised to clk) and the byte FIFO.
// PARAMETERS
//   SAMPLE_BYTES   3          bytes per channel sample (1..4)
//   CHANNELS       1          channels per frame (1..8)
//   SYNC_INTERVAL  128        frames between sync words; 0 = sync disabled
//   SYNC_BYTES     3          sync word length in bytes (1..4)
//   SYNC_WORD      24'hAAFF00 sync pattern, SYNC_BYTES*8 bits wide
//   CNT_WIDTH      16         width of drop_count
// PORTS
//   clk          in   1                         system clock
//   rst          in   1                         synchronous reset, active-high
//   enable       in   1                         accept new frames when high
//   frame_valid  in   1                         one-cycle pulse: frame_data valid
//   frame_data   in   CHANNELS*SAMPLE_BYTES*8   channel c at bits [c*SAMPLE_BYTES*8 +: SAMPLE_BYTES*8]
//   byte_data    out  8                         output byte
//   byte_valid   out  1                         byte_data valid
//   byte_ready   in   1                         sink accepts byte (FIFO !full)
//   busy         out  1                         frame/sync emission in progress
//   drop_count   out  CNT_WIDTH                 saturating count of dropped frames
// BEHAVIOUR
//   Reset: byte_valid=0, byte_data=0, busy=0, drop_count=0, FSM=IDLE, frame counter=0.
//   States: IDLE -> (SYNC) -> DATA -> IDLE.
//   IDLE: on frame_valid && enable, latch frame_data, busy=1 next cycle;
//     go SYNC if SYNC_INTERVAL!=0 and frame counter==0, else DATA.
//   Frame counter increments per accepted frame, wraps SYNC_INTERVAL-1 -> 0.
//   SYNC: emits SYNC_WORD bytes LSB first (default: 00, FF, AA), then DATA.
//   DATA: channel 0 first; each sample LSB first; CHANNELS*SAMPLE_BYTES bytes, then IDLE.
//   Latency: first byte_valid in cycle after accepting frame_valid.
//   Handshake: byte transfers when byte_valid && byte_ready; byte_data/byte_valid hold
//     stable while byte_ready=0; max throughput one byte per cycle, no bubbles.
//   Back-to-back: frame_valid in same cycle as final byte transfer is accepted (no gap).
//   frame_valid while busy (other than above) or while enable=0: frame dropped,
//     drop_count += 1, saturates at all-ones; latched frame untouched.
//   enable deasserted mid-frame: current frame (and its sync) completes.
//   busy=1 from cycle after accept until cycle after final byte transfer, unless back-to-back.
//   Reset mid-frame: partial frame discarded, no further bytes, counters cleared.
//   Widths: byte index counter sized $clog2(CHANNELS*SAMPLE_BYTES+1); no truncation.
// TESTING
//   Defaults, byte_ready=1, frame 24'h123456 -> bytes 00,FF,AA,56,34,12 on consecutive cycles.
//   Second frame 24'hABCDEF right after -> bytes EF,CD,AB only (no sync); 129th frame -> sync again.
//   CHANNELS=2, SAMPLE_BYTES=2, SYNC_INTERVAL=0, data 32'hBEEF_CAFE -> FE,CA,EF,BE.
//   byte_ready low 5 cycles after first sync byte -> byte_data holds FF, nothing lost/duplicated.
//   frame_valid pulsed mid-emission -> drop_count=1, stream unchanged; enable=0 pulse -> drop_count=2.
//   rst asserted after 2 data bytes -> byte_valid=0 next cycle; next frame starts with sync.

Source files
------------

// File: rtl/pcm_frame_packer.sv
// Serialises multi-channel PCM frames into a byte stream (LSB first, channel 0 first),
// with a periodic sync word so the host can realign, and drop counting for overrun frames.
module pcm_frame_packer #(
  parameter int                        SAMPLE_BYTES  = 3,
  parameter int                        CHANNELS      = 1,
  parameter int                        SYNC_INTERVAL = 128,
  parameter int                        SYNC_BYTES    = 3,
  parameter logic [SYNC_BYTES*8-1:0]   SYNC_WORD     = 24'hAAFF00,
  parameter int                        CNT_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               frame_valid,
  input  logic [CHANNELS*SAMPLE_BYTES*8-1:0] frame_data,
  output logic [7:0]                         byte_data,
  output logic                               byte_valid,
  input  logic                               byte_ready,
  output logic                               busy,
  output logic [CNT_WIDTH-1:0]               drop_count
);

  localparam int FRAME_BYTES = CHANNELS * SAMPLE_BYTES;
  localparam int MAX_BYTES   = (FRAME_BYTES > SYNC_BYTES) ? FRAME_BYTES : SYNC_BYTES;
  // The byte index walks both the sync word and the frame, so it covers the longer one.
  localparam int IDX_W       = $clog2(MAX_BYTES + 1);
  localparam int FC_W        = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
  localparam bit SYNC_EN     = (SYNC_INTERVAL != 0);
  localparam int LAST_FC     = SYNC_EN ? SYNC_INTERVAL - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [FC_W-1:0]              fcnt_q;
  logic [FRAME_BYTES*8-1:0]     frame_q;
  logic [FRAME_BYTES*8-1:0]     frame_src;
  logic [MAX_BYTES*8-1:0]       frame_pad;
  logic [MAX_BYTES*8-1:0]       sync_pad;
  logic [7:0]                   next_byte;
  logic                         xfer;
  logic                         sync_last;
  logic                         data_last;
  logic                         frame_done;
  logic                         accept;
  logic                         drop;
  logic                         start_sync;

  assign xfer       = byte_valid && byte_ready;
  assign sync_last  = (idx_q == IDX_W'(SYNC_BYTES - 1));
  assign data_last  = (idx_q == IDX_W'(FRAME_BYTES - 1));
  assign frame_done = xfer && (state_q == S_DATA) && data_last;
  // A new frame is taken when idle, or on the very cycle the last byte leaves (no gap).
  assign accept     = frame_valid && enable && ((state_q == S_IDLE) || frame_done);
  assign drop       = frame_valid && !accept;
  assign start_sync = SYNC_EN && (fcnt_q == '0);

  assign byte_valid = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_SYNC: begin
        if (xfer) begin
          if (sync_last) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (data_last) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d = start_sync ? S_SYNC : S_DATA;
      idx_d   = '0;
    end
  end

  // Byte lookup uses the incoming frame on the accept cycle so the first byte is not delayed.
  assign frame_src = accept ? frame_data : frame_q;
  assign frame_pad = (MAX_BYTES*8)'(frame_src);
  assign sync_pad  = (MAX_BYTES*8)'(SYNC_WORD);
  assign next_byte = (state_d == S_SYNC) ? sync_pad[8*int'(idx_d) +: 8]
                                         : frame_pad[8*int'(idx_d) +: 8];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      byte_data  <= '0;
      fcnt_q     <= '0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_d != S_IDLE) begin
        byte_data <= next_byte;
      end
      if (accept) begin
        if (!SYNC_EN || (fcnt_q == FC_W'(LAST_FC))) begin
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + FC_W'(1);
        end
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

  // NOTE: the frame holding register is pure datapath, only read after an accept loads it,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_q <= frame_data;
    end
  end

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Directed bench for pcm_frame_packer: default instance (1ch x 3B, sync every 128 frames)
// and a 2ch x 2B instance with sync disabled and a 2-bit drop counter.
module tb_pcm_frame_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_enable, a_fv, a_ready, a_bv, a_busy;
  logic [23:0] a_fd;
  logic [7:0]  a_bd;
  logic [15:0] a_dc;
  logic        b_enable, b_fv, b_ready, b_bv, b_busy;
  logic [31:0] b_fd;
  logic [7:0]  b_bd;
  logic [1:0]  b_dc;

  pcm_frame_packer dut_a (
    .clk(clk), .rst(rst), .enable(a_enable), .frame_valid(a_fv), .frame_data(a_fd),
    .byte_data(a_bd), .byte_valid(a_bv), .byte_ready(a_ready), .busy(a_busy),
    .drop_count(a_dc)
  );

  pcm_frame_packer #(
    .SAMPLE_BYTES(2), .CHANNELS(2), .SYNC_INTERVAL(0), .CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .frame_valid(b_fv), .frame_data(b_fd),
    .byte_data(b_bd), .byte_valid(b_bv), .byte_ready(b_ready), .busy(b_busy),
    .drop_count(b_dc)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [23:0] data;
    int          nb;
    logic [7:0]  b[6];
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_bytes(input bit sel, input string tag, input bq_t exp);
    foreach (exp[i]) begin
      @(negedge clk);
      check($sformatf("%s valid%0d", tag, i), sel ? b_bv : a_bv, 1);
      check($sformatf("%s byte%0d", tag, i), sel ? b_bd : a_bd, exp[i]);
    end
  endtask

  task automatic expect_idle(input bit sel, input string tag);
    @(negedge clk);
    check({tag, " idle valid"}, sel ? b_bv : a_bv, 0);
    check({tag, " idle busy"}, sel ? b_busy : a_busy, 0);
  endtask

  task automatic send_a(input logic [23:0] d);
    @(posedge clk); #1;
    a_fd = d;
    a_fv = 1'b1;
    @(posedge clk); #1;
    a_fv = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d);
    @(posedge clk); #1;
    b_fd = d;
    b_fv = 1'b1;
    @(posedge clk); #1;
    b_fv = 1'b0;
  endtask

  // Expected stream for the default instance: sync 00,FF,AA when due, then sample LSB first.
  function automatic bq_t model_a(input logic [23:0] d, input bit with_sync);
    bq_t         q;
    logic [23:0] s;
    s = 24'hAAFF00;
    q = {};
    if (with_sync) for (int i = 0; i < 3; i++) q.push_back(s[8*i +: 8]);
    for (int i = 0; i < 3; i++) q.push_back(d[8*i +: 8]);
    return q;
  endfunction

  initial begin
    vec_t        tbl[5];
    bq_t         q;
    logic [23:0] d;

    rst = 1'b1;
    a_enable = 1'b1; a_fv = 1'b0; a_ready = 1'b1; a_fd = '0;
    b_enable = 1'b1; b_fv = 1'b0; b_ready = 1'b1; b_fd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst a valid", a_bv, 0);
    check("rst a data", a_bd, 0);
    check("rst a busy", a_busy, 0);
    check("rst a drops", a_dc, 0);
    check("rst b valid", b_bv, 0);
    check("rst b drops", b_dc, 0);
    rst = 1'b0;

    tbl[0] = '{24'h123456, 6, '{8'h00, 8'hFF, 8'hAA, 8'h56, 8'h34, 8'h12}};
    tbl[1] = '{24'hABCDEF, 3, '{8'hEF, 8'hCD, 8'hAB, 8'h00, 8'h00, 8'h00}};
    tbl[2] = '{24'h000000, 3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[3] = '{24'hFFFFFF, 3, '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}};
    tbl[4] = '{24'h80017F, 3, '{8'h7F, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00}};

    for (int i = 0; i < 5; i++) begin
      send_a(tbl[i].data);
      n_frames++;
      q = {};
      for (int j = 0; j < tbl[i].nb; j++) q.push_back(tbl[i].b[j]);
      expect_bytes(0, $sformatf("vec%0d", i), q);
      expect_idle(0, $sformatf("vec%0d", i));
    end

    // Fill up to frame 127; frame 128 must carry the sync word again.
    while (n_frames < 128) begin
      d = {8'(n_frames), 8'(~n_frames), 8'(n_frames * 3)};
      send_a(d);
      expect_bytes(0, $sformatf("frm%0d", n_frames), model_a(d, (n_frames % 128) == 0));
      n_frames++;
      expect_idle(0, "fill");
    end

    // Frame 128: sync again, with the sink stalled for 5 cycles after the first sync byte.
    send_a(24'hC0FFEE);
    n_frames++;
    q = {8'h00};
    expect_bytes(0, "stall head", q);
    @(posedge clk); #1;
    a_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall valid", a_bv, 1);
      check("stall hold", a_bd, 8'hFF);
    end
    @(posedge clk); #1;
    a_ready = 1'b1;
    q = {8'hFF, 8'hAA, 8'hEE, 8'hFF, 8'hC0};
    expect_bytes(0, "stall tail", q);
    expect_idle(0, "stall");

    // Frame pulsed mid-emission is dropped; latched frame streams out unchanged.
    send_a(24'h445566);
    n_frames++;
    q = {8'h66};
    expect_bytes(0, "drop", q);
    a_fd = 24'h999999;
    a_fv = 1'b1;
    q = {8'h55};
    expect_bytes(0, "drop mid", q);
    a_fv = 1'b0;
    q = {8'h44};
    expect_bytes(0, "drop end", q);
    expect_idle(0, "drop");
    check("drop count 1", a_dc, 1);

    // Back-to-back: new frame offered on the final-byte cycle follows with no gap.
    send_a(24'h0A0B0C);
    n_frames++;
    q = {8'h0C, 8'h0B, 8'h0A};
    expect_bytes(0, "b2b first", q);
    a_fd = 24'h1D2E3F;
    a_fv = 1'b1;
    q = {8'h3F};
    expect_bytes(0, "b2b second", q);
    a_fv = 1'b0;
    check("b2b busy", a_busy, 1);
    n_frames++;
    q = {8'h2E, 8'h1D};
    expect_bytes(0, "b2b rest", q);
    expect_idle(0, "b2b");
    check("b2b no drop", a_dc, 1);

    // enable low: frame dropped, nothing emitted.
    @(negedge clk);
    a_enable = 1'b0;
    a_fd = 24'h777777;
    a_fv = 1'b1;
    @(negedge clk);
    a_fv = 1'b0;
    a_enable = 1'b1;
    check("en drop valid", a_bv, 0);
    check("drop count 2", a_dc, 2);

    // Second instance: 2ch x 2B, sync disabled.
    send_b(32'hBEEF_CAFE);
    q = {8'hFE, 8'hCA, 8'hEF, 8'hBE};
    expect_bytes(1, "b frame0", q);
    expect_idle(1, "b frame0");
    send_b(32'h0123_4567);
    q = {8'h67, 8'h45, 8'h23, 8'h01};
    expect_bytes(1, "b frame1", q);
    expect_idle(1, "b frame1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_enable = 1'b0;
      b_fv = 1'b1;
      @(negedge clk);
      b_fv = 1'b0;
      b_enable = 1'b1;
      if (i == 1) check("b drops 2", b_dc, 2);
    end
    check("b drops saturate", b_dc, 3);

    // Reset after two data bytes: output stops, counters clear, next frame restarts with sync.
    send_a(24'h314159);
    q = {8'h59, 8'h41};
    expect_bytes(0, "rst mid", q);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid valid", a_bv, 0);
    check("rst mid busy", a_busy, 0);
    check("rst mid drops", a_dc, 0);
    check("rst mid b drops", b_dc, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst quiet", a_bv, 0);
    n_frames = 0;
    d = 24'h271828;
    send_a(d);
    expect_bytes(0, "post rst", model_a(d, 1'b1));
    expect_idle(0, "post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
